// File: rtl/perf_test_core.sv
// Link performance test core: LFSR symbol source, 4-level slicer and per-cycle
// measurements of reference level, power and slicer error over one LFSR cycle.
module perf_test_core #(
  parameter int LFSR_LEN = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [17:0]         rx_channel_sync,
  output logic                       sam_clk_en,
  output logic                       sym_clk_en,
  output logic [3:0]                 clk_phase,
  output logic [21:0]                seq_out,
  output logic [3:0]                 sym_out,
  output logic                       cycle_out_once,
  output logic                       cycle_out_periodic,
  output logic                       cycle_out_periodic_ahead,
  output logic                       cycle_out_periodic_behind,
  output logic [LFSR_LEN-1:0]        lfsr_counter,
  output logic [1:0]                 rx_data,
  output logic signed [17:0]         ref_level,
  output logic signed [17:0]         avg_power,
  output logic signed [17:0]         acc_err_sq,
  output logic signed [17:0]         acc_err_dc
);

  localparam int ACC_W = 18 + LFSR_LEN + 2;
  localparam logic [LFSR_LEN-1:0] CNT_LAST  = {{(LFSR_LEN-1){1'b1}}, 1'b0};
  localparam logic [LFSR_LEN-1:0] CNT_AHEAD = CNT_LAST - LFSR_LEN'(1);
  localparam logic signed [17:0] REF_DEFAULT = 18'sd16384;

  logic                      wrapped_reg;
  logic [LFSR_LEN-1:0]       cnt_next;
  logic signed [20:0]        x_w;
  logic signed [20:0]        r_w;
  logic signed [20:0]        two_r;
  logic signed [20:0]        level_w;
  logic signed [20:0]        e_w;
  logic signed [17:0]        e_sat;
  logic [1:0]                slice_next;
  logic [17:0]               abs_x;
  logic signed [35:0]        x_sq;
  logic signed [35:0]        e_sq;
  logic [17:0]               x_sq_hi;
  logic [17:0]               e_sq_hi;
  logic [ACC_W-1:0]          acc_abs_reg;
  logic [ACC_W-1:0]          acc_xsq_reg;
  logic [ACC_W-1:0]          acc_esq_reg;
  logic signed [ACC_W-1:0]   acc_e_reg;
  logic [ACC_W-1:0]          term_abs;
  logic [ACC_W-1:0]          term_xsq;
  logic [ACC_W-1:0]          term_esq;
  logic signed [ACC_W-1:0]   term_e;
  logic signed [ACC_W-1:0]   dc_shift;

  assign sam_clk_en = &clk_phase[1:0];
  assign sym_clk_en = &clk_phase;
  assign sym_out    = seq_out[3:0];
  assign cnt_next   = (lfsr_counter == CNT_LAST) ? '0 : lfsr_counter + LFSR_LEN'(1);

  // Slicer and error path operate directly on the sample taken at the symbol strobe;
  // 21-bit intermediates keep +/-3R and x-level free of overflow before saturation.
  always_comb begin
    x_w   = 21'(rx_channel_sync);
    r_w   = 21'(ref_level);
    two_r = r_w <<< 1;

    slice_next = 2'b11;
    if (x_w < -two_r)     slice_next = 2'b00;
    else if (x_w < 0)     slice_next = 2'b01;
    else if (x_w < two_r) slice_next = 2'b10;

    level_w = two_r + r_w;
    case (slice_next)
      2'b00:   level_w = -(two_r + r_w);
      2'b01:   level_w = -r_w;
      2'b10:   level_w = r_w;
      default: level_w = two_r + r_w;
    endcase

    e_w = x_w - level_w;
    if (e_w > 21'sd131071)       e_sat = 18'sd131071;
    else if (e_w < -21'sd131072) e_sat = -18'sd131072;
    else                         e_sat = 18'(e_w);

    abs_x   = 18'((x_w < 0) ? -x_w : x_w);
    x_sq    = rx_channel_sync * rx_channel_sync;
    e_sq    = e_sat * e_sat;
    x_sq_hi = 18'(x_sq >>> 18);
    e_sq_hi = 18'(e_sq >>> 18);

    term_abs = {{(ACC_W-18){1'b0}}, abs_x};
    term_xsq = {{(ACC_W-18){1'b0}}, x_sq_hi};
    term_esq = {{(ACC_W-18){1'b0}}, e_sq_hi};
    term_e   = {{(ACC_W-18){e_sat[17]}}, e_sat};
    dc_shift = acc_e_reg >>> LFSR_LEN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_phase                 <= '0;
      seq_out                   <= 22'h000001;
      lfsr_counter              <= '0;
      wrapped_reg               <= 1'b0;
      cycle_out_once            <= 1'b0;
      cycle_out_periodic        <= 1'b0;
      cycle_out_periodic_ahead  <= 1'b0;
      cycle_out_periodic_behind <= 1'b0;
      rx_data                   <= 2'b00;
      acc_abs_reg               <= '0;
      acc_xsq_reg               <= '0;
      acc_esq_reg               <= '0;
      acc_e_reg                 <= '0;
      ref_level                 <= REF_DEFAULT;
      avg_power                 <= '0;
      acc_err_sq                <= '0;
      acc_err_dc                <= '0;
    end else begin
      clk_phase <= clk_phase + 4'd1;
      if (sym_clk_en) begin
        seq_out                   <= {seq_out[20:0], seq_out[21] ^ seq_out[20]};
        lfsr_counter              <= cnt_next;
        wrapped_reg               <= wrapped_reg | (lfsr_counter == CNT_LAST);
        cycle_out_periodic        <= (cnt_next == CNT_LAST);
        cycle_out_periodic_ahead  <= (cnt_next == CNT_AHEAD);
        cycle_out_periodic_behind <= (lfsr_counter == CNT_LAST);
        cycle_out_once            <= (cnt_next == CNT_LAST) && !wrapped_reg;
        rx_data                   <= slice_next;
        // Close the measurement window: publish averages, then restart the sums
        // with this symbol's contribution.
        if (cycle_out_periodic_behind) begin
          ref_level   <= $signed(18'(acc_abs_reg >> (LFSR_LEN + 1)));
          avg_power   <= $signed(18'(acc_xsq_reg >> LFSR_LEN));
          acc_err_sq  <= $signed(18'(acc_esq_reg >> LFSR_LEN));
          acc_err_dc  <= 18'(dc_shift);
          acc_abs_reg <= term_abs;
          acc_xsq_reg <= term_xsq;
          acc_esq_reg <= term_esq;
          acc_e_reg   <= term_e;
        end else begin
          acc_abs_reg <= acc_abs_reg + term_abs;
          acc_xsq_reg <= acc_xsq_reg + term_xsq;
          acc_esq_reg <= acc_esq_reg + term_esq;
          acc_e_reg   <= acc_e_reg + term_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_test_core.sv
// Directed bench for perf_test_core: strobe timing, LFSR/counter/flags against a
// small reference model, slicer vector table and whole-cycle measurement cases.
module tb_perf_test_core;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [17:0] rx_channel_sync = '0;
  logic               sam_clk_en, sym_clk_en;
  logic [3:0]         clk_phase;
  logic [21:0]        seq_out;
  logic [3:0]         sym_out;
  logic               cycle_out_once, cycle_out_periodic;
  logic               cycle_out_periodic_ahead, cycle_out_periodic_behind;
  logic [5:0]         lfsr_counter;
  logic [1:0]         rx_data;
  logic signed [17:0] ref_level, avg_power, acc_err_sq, acc_err_dc;

  perf_test_core #(.LFSR_LEN(6)) dut (
    .clk(clk), .reset(reset), .rx_channel_sync(rx_channel_sync),
    .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en), .clk_phase(clk_phase),
    .seq_out(seq_out), .sym_out(sym_out),
    .cycle_out_once(cycle_out_once), .cycle_out_periodic(cycle_out_periodic),
    .cycle_out_periodic_ahead(cycle_out_periodic_ahead),
    .cycle_out_periodic_behind(cycle_out_periodic_behind),
    .lfsr_counter(lfsr_counter), .rx_data(rx_data), .ref_level(ref_level),
    .avg_power(avg_power), .acc_err_sq(acc_err_sq), .acc_err_dc(acc_err_dc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the symbol-rate state
  int          c_m;
  logic [21:0] seq_m;
  bit          wrapped_m;

  typedef struct {
    logic signed [17:0] x;
    logic [1:0]         exp_rx;
  } slice_vec_t;

  typedef struct {
    logic signed [17:0] x;
    logic [1:0]         exp_rx;
    int                 exp_ref;
    int                 exp_pow;
    int                 exp_esq;
    int                 exp_dc;
  } cycle_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_meas_default(input string tag);
    check({tag, "_ref_level"},  int'(ref_level),  16384);
    check({tag, "_avg_power"},  int'(avg_power),  0);
    check({tag, "_acc_err_sq"}, int'(acc_err_sq), 0);
    check({tag, "_acc_err_dc"}, int'(acc_err_dc), 0);
  endtask

  task automatic check_reset_state();
    check("rst_clk_phase", int'(clk_phase), 0);
    check("rst_sam_clk_en", int'(sam_clk_en), 0);
    check("rst_sym_clk_en", int'(sym_clk_en), 0);
    check("rst_seq_out", int'(seq_out), 1);
    check("rst_lfsr_counter", int'(lfsr_counter), 0);
    check("rst_flags", int'({cycle_out_once, cycle_out_periodic,
                             cycle_out_periodic_ahead, cycle_out_periodic_behind}), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check_meas_default("rst");
    $display("[TB] reset: phase=%0d seq=%06h cnt=%0d ref=%0d", clk_phase, seq_out,
             lfsr_counter, ref_level);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    c_m = 0; seq_m = 22'h000001; wrapped_m = 1'b0;
    reset = 1'b0;
  endtask

  // Advance one symbol from a negedge at phase 0: the 16th edge is the strobe edge.
  task automatic sym_step();
    repeat (16) @(posedge clk);
    @(negedge clk);
    seq_m = {seq_m[20:0], seq_m[21] ^ seq_m[20]};
    if (c_m == 62) begin c_m = 0; wrapped_m = 1'b1; end
    else c_m = c_m + 1;
  endtask

  task automatic check_model();
    check("lfsr_counter", int'(lfsr_counter), c_m);
    check("seq_out", int'(seq_out), int'(seq_m));
    check("sym_out", int'(sym_out), int'(seq_m[3:0]));
    check("cycle_periodic", int'(cycle_out_periodic), int'(c_m == 62));
    check("cycle_ahead", int'(cycle_out_periodic_ahead), int'(c_m == 61));
    check("cycle_behind", int'(cycle_out_periodic_behind), int'(c_m == 0 && wrapped_m));
    check("cycle_once", int'(cycle_out_once), int'(c_m == 62 && !wrapped_m));
  endtask

  // One full measurement window from reset: 63 accumulated symbols, update on the 64th strobe.
  task automatic run_cycle(input cycle_vec_t v, input string tag);
    rx_channel_sync = v.x;
    for (int s = 1; s <= 64; s++) begin
      sym_step();
      check_model();
      if (s == 1) check({tag, "_rx_data"}, int'(rx_data), int'(v.exp_rx));
      if (s == 63) check_meas_default({tag, "_hold"});
      if (s == 64) begin
        check({tag, "_ref_level"},  int'(ref_level),  v.exp_ref);
        check({tag, "_avg_power"},  int'(avg_power),  v.exp_pow);
        check({tag, "_acc_err_sq"}, int'(acc_err_sq), v.exp_esq);
        check({tag, "_acc_err_dc"}, int'(acc_err_dc), v.exp_dc);
        $display("[TB] cycle %s x=%0d: ref=%0d pow=%0d esq=%0d dc=%0d", tag, v.x,
                 ref_level, avg_power, acc_err_sq, acc_err_dc);
      end
    end
  endtask

  slice_vec_t slice_tab[10];
  cycle_vec_t cycle_tab[3];

  initial begin
    // Slicer with R=16384 (2R=32768)
    slice_tab[0] = '{18'sd49152,   2'b11};
    slice_tab[1] = '{-18'sd8000,   2'b01};
    slice_tab[2] = '{18'sd0,       2'b10};
    slice_tab[3] = '{18'sd32767,   2'b10};
    slice_tab[4] = '{18'sd32768,   2'b11};
    slice_tab[5] = '{-18'sd32768,  2'b01};
    slice_tab[6] = '{-18'sd32769,  2'b00};
    slice_tab[7] = '{-18'sd131072, 2'b00};
    slice_tab[8] = '{18'sd131071,  2'b11};
    slice_tab[9] = '{-18'sd1,      2'b01};
    // 63 equal terms per window:
    // x=49152: e=0; 63*49152>>7=24192; (49152^2>>18)=9216, 63*9216>>6=9072
    cycle_tab[0] = '{18'sd49152, 2'b11, 24192, 9072, 0, 0};
    // x=-8000: e=8384; |x| 504000>>7=3937; x^2 hi 244 -> 240; e^2 hi 268 -> 263; 528192>>>6=8253
    cycle_tab[1] = '{-18'sd8000, 2'b01, 3937, 240, 263, 8253};
    // x=8001: e=-8383; 504063>>7=3937; 240; 263; -528129>>>6 = -8253 (floor)
    cycle_tab[2] = '{18'sd8001,  2'b10, 3937, 240, 263, -8253};

    do_reset();

    // Strobe timing: after k edges clk_phase=k%16, strobes decode the phase.
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("clk_phase", int'(clk_phase), k % 16);
      check("sam_clk_en", int'(sam_clk_en), int'(k % 4 == 3));
      check("sym_clk_en", int'(sym_clk_en), int'(k % 16 == 15));
      if (k % 16 == 0) begin
        seq_m = {seq_m[20:0], seq_m[21] ^ seq_m[20]};
        c_m = c_m + 1;
      end
    end
    check("seq_after_3", int'(seq_out), 32'h8);
    check("cnt_after_3", int'(lfsr_counter), 3);
    $display("[TB] after 3 symbols: seq=%06h cnt=%0d", seq_out, lfsr_counter);

    // Slicer table, with a latency check one clk before each strobe edge.
    begin
      logic [1:0] prev_rx;
      prev_rx = 2'b10;
      for (int i = 0; i < 10; i++) begin
        rx_channel_sync = slice_tab[i].x;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("rx_data_hold", int'(rx_data), int'(prev_rx));
        @(posedge clk);
        @(negedge clk);
        seq_m = {seq_m[20:0], seq_m[21] ^ seq_m[20]};
        c_m = c_m + 1;
        check("rx_data_slice", int'(rx_data), int'(slice_tab[i].exp_rx));
        check_model();
        $display("[TB] slice x=%0d rx_data=%0b expected=%0b", slice_tab[i].x, rx_data,
                 slice_tab[i].exp_rx);
        prev_rx = slice_tab[i].exp_rx;
      end
    end

    // Whole-cycle measurement, then a reset halfway through the next window.
    do_reset();
    run_cycle(cycle_tab[0], "c49152");
    for (int s = 0; s < 30; s++) begin
      sym_step();
      check_model();
    end
    do_reset();
    run_cycle(cycle_tab[0], "c49152_after_midreset");

    for (int i = 1; i < 3; i++) begin
      do_reset();
      run_cycle(cycle_tab[i], $sformatf("c%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
